fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
- Sequential consumer of the PC+4 increment in the MIPS64 datapath.
- Holds the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request and a valid response.
- Delivers {pc, instr} to the decode stage over a valid/ready handoff.
- Accepts branch/jump redirects at any time and discards stale in-flight fetches.

Parameters:
SIZE, 64, PC/address width in bits
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset (word-aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
redirect_valid  input  1  branch/jump redirect this cycle
redirect_pc  input  SIZE  redirect target; bits [1:0] ignored, treated as 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  SIZE  fetch address, always equal to pc
imem_resp_valid  input  1  read data valid; one pulse per accepted request
imem_resp_data  input  INSTR_W  instruction word
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_pc  output  SIZE  PC of presented instruction
if_instr  output  INSTR_W  presented instruction

Behaviour:
- Registers:
  - pc (SIZE), reset RESET_PC.
  - instr_buf (INSTR_W), reset 0.
  - state, reset S_REQ.
- Outputs decode from state. While rst_n=0 at a clock edge, state and registers are reloaded.
- Output values after reset: imem_req_valid=1, imem_req_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0.
- Request fire = imem_req_valid & imem_req_ready. Decode transfer = if_valid & if_ready.
- Only one request is ever outstanding.
- States and transitions:
  - S_REQ: imem_req_valid=1.
    - redirect & !fire: pc<=redirect_pc, stay S_REQ. The address changes; memory samples only on fire.
    - redirect & fire: pc<=redirect_pc, go S_DROP.
    - fire only: go S_WAIT.
  - S_WAIT: imem_req_valid=0.
    - redirect & resp: pc<=redirect_pc, response discarded, go S_REQ.
    - redirect only: pc<=redirect_pc, go S_DROP.
    - resp only: instr_buf<=imem_resp_data, go S_HOLD.
  - S_DROP: awaits the stale response.
    - resp: discard, go S_REQ.
    - redirect: pc<=redirect_pc, stay in the current state unless resp also arrives, which goes to S_REQ.
  - S_HOLD: if_valid = !redirect_valid (redirect kills the held instruction combinationally); if_pc=pc, if_instr=instr_buf.
    - redirect: pc<=redirect_pc, go S_REQ.
    - transfer: pc<=pc+4, go S_REQ.
    - else hold, with outputs stable.
- Minimum latency: request fire in cycle N, response in cycle N+k → if_valid in cycle N+k+1. Peak throughput is one instruction per 3 cycles with zero-latency memory; this is acceptable for the multicycle core.
- Arithmetic:
  - pc+4 is modulo 2^SIZE; 0xFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
  - redirect_pc[1:0] is forced to 2'b00 on load.
- Priority: reset > redirect > response/transfer/fire.
- Reset mid-fetch (S_WAIT/S_DROP): state returns to S_REQ. Any late imem_resp_valid in S_REQ is ignored.
- imem_resp_valid in S_REQ or S_HOLD is a protocol violation and is ignored (assertion in the bench).

Decomposition:
- Shared package:
  - state encoding (S_REQ, S_WAIT, S_DROP, S_HOLD, 2 bits)
  - PC_INCR=4
  - RESET_PC default
- Sub-module: the PC increment uses the team's existing parameterized add-four adder, instantiated with SIZE passed through. No other sub-module is needed.

Test Plan:
- Reset, memory ready, 1-cycle response returning 0x2408_0001 at addr 0:
  - → cycle after reset: imem_req_addr=0.
  - → if_valid with if_pc=0, if_instr=0x24080001.
  - → after if_ready, next request addr=4.
- if_ready held 0 for 5 cycles in S_HOLD:
  - → if_valid=1, if_pc and if_instr stable.
  - → no new request.
  - → pc advances only on the ready cycle.
- Redirect to 0x1003 during S_WAIT, response arrives 2 cycles later:
  - → response dropped, if_valid never asserted for it.
  - → next request addr=0x1000.
- Redirect coincident with fire in S_REQ (pc=8, target 0x40):
  - → S_DROP; the stale response is discarded.
  - → next request addr=0x40.
- pc=0xFFFF_FFFF_FFFF_FFFC delivered and accepted:
  - → next imem_req_addr=0.
- rst_n=0 for one cycle while in S_WAIT:
  - → imem_req_valid=1, addr=RESET_PC next cycle.
  - → late response ignored.
  - → if_valid stays 0.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: FSM encoding and PC constants.
package fetch_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int          PC_INCR          = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_pc_ctrl_add4.sv
// Parameterized add-four adder; wraps modulo 2^SIZE with no carry out.
module fetch_pc_ctrl_add4
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic [SIZE-1:0] a,
    output logic [SIZE-1:0] sum
);

    assign sum = a + SIZE'(PC_INCR);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: one outstanding instruction-memory read, redirectable at any time,
// handing {pc, instr} to decode over a valid/ready interface.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int              SIZE     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [SIZE-1:0] RESET_PC = SIZE'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [SIZE-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [SIZE-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [SIZE-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    localparam logic [SIZE-1:0] ALIGN_MASK = ~SIZE'(3);

    state_t              state, state_next;
    logic [SIZE-1:0]     pc, pc_next, pc_plus4;
    logic [INSTR_W-1:0]  instr_buf;
    logic                buf_load;
    logic                fire;
    logic [SIZE-1:0]     redirect_target;

    fetch_pc_ctrl_add4 #(.SIZE(SIZE)) u_add4 (
        .a   (pc),
        .sum (pc_plus4)
    );

    assign fire            = imem_req_valid & imem_req_ready;
    assign redirect_target = redirect_pc & ALIGN_MASK;

    // State register plus the PC and instruction buffer it steers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            instr_buf <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (buf_load) begin
                instr_buf <= imem_resp_data;
            end
        end
    end

    // Redirect outranks every other event; a redirect with a request in flight must
    // first swallow the stale response (S_DROP) before issuing the new fetch.
    always_comb begin
        // NOTE: defaults up front so no path through the case leaves a latch.
        state_next = state;
        pc_next    = pc;
        buf_load   = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = fire ? S_DROP : S_REQ;
                end else if (fire) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    buf_load   = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = S_REQ;
                end else if (if_ready) begin
                    pc_next    = pc_plus4;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if_valid       = 1'b0;
        unique case (state)
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  if_valid       = !redirect_valid;
            default: ;
        endcase
    end

    assign imem_req_addr = pc;
    assign if_pc         = pc;
    assign if_instr      = instr_buf;

endmodule
